// File: rtl/acc_stream_dispatch.sv
// Routes one DMA stream pair to one of N_ENG engines and buffers results in a show-ahead FIFO.
// Optional error flag logic is built when ACC_DISPATCH_ERR_EN is defined.
module acc_stream_dispatch #(
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned N_ENG      = 3,
    parameter int unsigned FIFO_DEPTH = 64,
    parameter int unsigned LEN_W      = 7
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [N_ENG-1:0]        ap_start,
    input  logic [LEN_W-1:0]        out_len,
    output logic                    ap_idle,
    output logic [N_ENG-1:0]        ap_done,
    output logic                    err,
    input  logic                    ss_tvalid,
    input  logic [DATA_W-1:0]       ss_tdata,
    input  logic                    ss_tlast,
    output logic                    ss_tready,
    output logic [N_ENG-1:0]        eng_ss_tvalid,
    output logic [DATA_W-1:0]       eng_ss_tdata,
    output logic                    eng_ss_tlast,
    input  logic [N_ENG-1:0]        eng_ss_tready,
    input  logic [N_ENG*DATA_W-1:0] eng_dout,
    input  logic [N_ENG-1:0]        eng_dvalid,
    output logic [N_ENG-1:0]        eng_dready,
    input  logic                    sm_tready,
    output logic                    sm_tvalid,
    output logic [DATA_W-1:0]       sm_tdata,
    output logic                    sm_tlast
);

    localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]        state;
    logic [1:0]        state_nxt;
    logic [N_ENG-1:0]  sel;
    logic [LEN_W-1:0]  len;
    logic [LEN_W-1:0]  wr_cnt;
    logic [LEN_W-1:0]  rd_cnt;
    logic [DATA_W-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  count;
    logic [DATA_W-1:0] res_data;
    logic              start_onehot;
    logic              start_ok;
    logic              fifo_full;
    logic              fifo_empty;
    logic              in_run;
    logic              in_out;
    logic              res_valid;
    logic              wr_en;
    logic              rd_en;

    assign start_onehot = (ap_start != '0) && ((ap_start & (ap_start - N_ENG'(1))) == '0);
    assign start_ok     = (state == S_IDLE) && start_onehot && (out_len != '0);
    assign fifo_full    = (count == CNT_W'(FIFO_DEPTH));
    assign fifo_empty   = (count == '0);
    assign in_run       = (state == S_RUN);
    assign in_out       = (state == S_RUN) || (state == S_DRAIN);

    // One-hot AND-OR select of the active engine's result word
    always_comb begin
        res_data = '0;
        for (int unsigned i = 0; i < N_ENG; i++) begin
            if (sel[i]) begin
                res_data = res_data | eng_dout[i*DATA_W +: DATA_W];
            end
        end
    end

    assign res_valid = |(eng_dvalid & sel);
    assign wr_en     = in_run && !fifo_full && res_valid;
    assign rd_en     = sm_tvalid && sm_tready;

    assign ss_tready     = in_run && (|(eng_ss_tready & sel));
    assign eng_ss_tvalid = (in_run && ss_tvalid) ? sel : '0;
    assign eng_ss_tdata  = ss_tdata;
    assign eng_ss_tlast  = ss_tlast;
    assign eng_dready    = (in_run && !fifo_full) ? sel : '0;

    assign sm_tvalid = in_out && !fifo_empty;
    assign sm_tdata  = sm_tvalid ? mem[rd_ptr] : '0;
    assign sm_tlast  = sm_tvalid && (rd_cnt == len - LEN_W'(1));

    assign ap_idle = (state == S_IDLE);
    assign ap_done = (state == S_DONE) ? sel : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (start_ok) state_nxt = S_RUN;
            S_RUN:   if (wr_en && (wr_cnt == len - LEN_W'(1))) state_nxt = S_DRAIN;
            S_DRAIN: if (rd_en && (rd_cnt == len - LEN_W'(1))) state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Job context, counters and FIFO bookkeeping; a legal start flushes the FIFO
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel    <= '0;
            len    <= '0;
            wr_cnt <= '0;
            rd_cnt <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (start_ok) begin
            sel    <= ap_start;
            len    <= out_len;
            wr_cnt <= '0;
            rd_cnt <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
                wr_cnt <= wr_cnt + LEN_W'(1);
            end
            if (rd_en) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
                rd_cnt <= rd_cnt + LEN_W'(1);
            end
            case ({wr_en, rd_en})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= res_data;
        end
    end

`ifdef ACC_DISPATCH_ERR_EN
    logic err_q;
    logic illegal_start;
    logic drop;

    assign illegal_start = (state == S_IDLE) && (ap_start != '0) && !(start_onehot && (out_len != '0));
    assign drop          = (state == S_DRAIN) && res_valid;

    // Sticky until the next accepted start
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else if (start_ok) begin
            err_q <= 1'b0;
        end else if (illegal_start || drop) begin
            err_q <= 1'b1;
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_acc_stream_dispatch.sv
// Scoreboard bench for acc_stream_dispatch: directed jobs, decoupled output monitor.
module tb_acc_stream_dispatch;

    localparam int unsigned DATA_W     = 32;
    localparam int unsigned N_ENG      = 3;
    localparam int unsigned FIFO_DEPTH = 64;
    localparam int unsigned LEN_W      = 7;

`ifdef ACC_DISPATCH_ERR_EN
    localparam logic ERR_ON = 1'b1;
`else
    localparam logic ERR_ON = 1'b0;
`endif

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic              last;
    } exp_t;

    logic                    clk;
    logic                    rst_n;
    logic [N_ENG-1:0]        ap_start;
    logic [LEN_W-1:0]        out_len;
    logic                    ap_idle;
    logic [N_ENG-1:0]        ap_done;
    logic                    err;
    logic                    ss_tvalid;
    logic [DATA_W-1:0]       ss_tdata;
    logic                    ss_tlast;
    logic                    ss_tready;
    logic [N_ENG-1:0]        eng_ss_tvalid;
    logic [DATA_W-1:0]       eng_ss_tdata;
    logic                    eng_ss_tlast;
    logic [N_ENG-1:0]        eng_ss_tready;
    logic [N_ENG*DATA_W-1:0] eng_dout;
    logic [N_ENG-1:0]        eng_dvalid;
    logic [N_ENG-1:0]        eng_dready;
    logic                    sm_tready;
    logic                    sm_tvalid;
    logic [DATA_W-1:0]       sm_tdata;
    logic                    sm_tlast;

    int checks = 0;
    int errors = 0;
    exp_t exp_q[$];

    // Source / engine model state
    int src_n = 0, src_idx = 0;
    int res_eng = 0, res_n = 0, res_idx = 0;
    logic [DATA_W-1:0] res_base = '0;
    int in_hs[N_ENG];
    bit route_toggle = 0;
    bit chk_route = 0;
    logic [N_ENG-1:0] job_sel = '0;

    acc_stream_dispatch #(
        .DATA_W(DATA_W), .N_ENG(N_ENG), .FIFO_DEPTH(FIFO_DEPTH), .LEN_W(LEN_W)
    ) dut (
        .clk(clk), .rst_n(rst_n), .ap_start(ap_start), .out_len(out_len),
        .ap_idle(ap_idle), .ap_done(ap_done), .err(err),
        .ss_tvalid(ss_tvalid), .ss_tdata(ss_tdata), .ss_tlast(ss_tlast), .ss_tready(ss_tready),
        .eng_ss_tvalid(eng_ss_tvalid), .eng_ss_tdata(eng_ss_tdata), .eng_ss_tlast(eng_ss_tlast),
        .eng_ss_tready(eng_ss_tready), .eng_dout(eng_dout), .eng_dvalid(eng_dvalid),
        .eng_dready(eng_dready), .sm_tready(sm_tready), .sm_tvalid(sm_tvalid),
        .sm_tdata(sm_tdata), .sm_tlast(sm_tlast)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h required %0h", name, act, req);
        end
    endtask

    // DMA source and engine result drivers
    always_comb begin
        ss_tvalid  = (src_idx < src_n);
        ss_tdata   = DATA_W'(src_idx);
        ss_tlast   = (src_idx == src_n - 1);
        eng_dvalid = '0;
        eng_dout   = '0;
        if (res_idx < res_n) eng_dvalid[res_eng] = 1'b1;
        eng_dout[res_eng*DATA_W +: DATA_W] = res_base + DATA_W'(res_idx);
    end

    // Advance models on handshakes sampled mid-cycle
    initial begin
        bit s_hs, r_hs;
        logic [N_ENG-1:0] e_hs;
        forever begin
            @(negedge clk);
            s_hs = ss_tvalid && ss_tready;
            r_hs = eng_dvalid[res_eng] && eng_dready[res_eng];
            e_hs = eng_ss_tvalid & eng_ss_tready;
            @(posedge clk);
            #1;
            if (s_hs) src_idx++;
            if (r_hs) res_idx++;
            for (int i = 0; i < N_ENG; i++) if (e_hs[i]) in_hs[i]++;
            if (route_toggle) eng_ss_tready[2] = ~eng_ss_tready[2];
        end
    end

    // Output monitor: scoreboard pop, data stability, ap_done timing, routing
    initial begin
        bit last_hs = 0, prev_stall = 0;
        logic [DATA_W-1:0] prev_data = '0;
        logic prev_last = 1'b0;
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                last_hs = 0;
                prev_stall = 0;
            end else begin
                if (last_hs) check("ap_done_pulse", 64'(ap_done), 64'(job_sel));
                else if (ap_done != '0) check("ap_done_spurious", 64'(ap_done), 64'(0));
                if (prev_stall) begin
                    check("hold_tvalid", 64'(sm_tvalid), 64'(1));
                    check("hold_tdata", 64'(sm_tdata), 64'(prev_data));
                    check("hold_tlast", 64'(sm_tlast), 64'(prev_last));
                end
                last_hs = 0;
                if (sm_tvalid && sm_tready) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL sm_extra_word: got %0h required no word", sm_tdata);
                    end else begin
                        e = exp_q.pop_front();
                        check("sm_tdata", 64'(sm_tdata), 64'(e.data));
                        check("sm_tlast", 64'(sm_tlast), 64'(e.last));
                        last_hs = e.last;
                    end
                end
                prev_stall = sm_tvalid && !sm_tready;
                prev_data  = sm_tdata;
                prev_last  = sm_tlast;
                if (chk_route) begin
                    check("route_other_valid", 64'(eng_ss_tvalid[1:0]), 64'(0));
                    check("route_tdata", 64'(eng_ss_tdata), 64'(ss_tdata));
                    check("route_tlast", 64'(eng_ss_tlast), 64'(ss_tlast));
                    if (eng_ss_tvalid[2]) check("route_ready", 64'(ss_tready), 64'(eng_ss_tready[2]));
                end
            end
        end
    end

    task automatic start_job(input int eng, input int len, input int n_in, input int n_res, input int base);
        exp_t e;
        @(posedge clk);
        #1;
        src_n = n_in; src_idx = 0;
        res_eng = eng; res_n = n_res; res_idx = 0; res_base = DATA_W'(base);
        for (int i = 0; i < N_ENG; i++) in_hs[i] = 0;
        for (int k = 0; k < len && k < n_res; k++) begin
            e.data = DATA_W'(base + k);
            e.last = (k == len - 1);
            exp_q.push_back(e);
        end
        job_sel  = N_ENG'(1) << eng;
        ap_start = job_sel;
        out_len  = LEN_W'(len);
        @(posedge clk);
        #1;
        ap_start = '0;
        out_len  = '0;
        @(negedge clk);
        check("start_idle_low", 64'(ap_idle), 64'(0));
        check("start_err_clear", 64'(err), 64'(0));
    endtask

    task automatic wait_done(input int limit);
        bit seen = 0;
        for (int i = 0; i < limit; i++) begin
            @(negedge clk);
            if (ap_done != '0) begin
                seen = 1;
                break;
            end
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL done_timeout: got no ap_done required within %0d cycles", limit);
        end else begin
            check("done_idle_low", 64'(ap_idle), 64'(0));
            @(negedge clk);
            check("idle_after_done", 64'(ap_idle), 64'(1));
        end
        check("scoreboard_empty", 64'(exp_q.size()), 64'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout required $finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0; ap_start = '0; out_len = '0;
        eng_ss_tready = '1; sm_tready = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_ap_idle", 64'(ap_idle), 64'(1));
        check("rst_ap_done", 64'(ap_done), 64'(0));
        check("rst_err", 64'(err), 64'(0));
        check("rst_ss_tready", 64'(ss_tready), 64'(0));
        check("rst_eng_ss_tvalid", 64'(eng_ss_tvalid), 64'(0));
        check("rst_eng_dready", 64'(eng_dready), 64'(0));
        check("rst_sm_tvalid", 64'(sm_tvalid), 64'(0));
        check("rst_sm_tlast", 64'(sm_tlast), 64'(0));
        check("rst_sm_tdata", 64'(sm_tdata), 64'(0));
        @(posedge clk); #1; rst_n = 1'b1;

        // Normal job: engine 0, 64 words 0..63
        start_job(0, 64, 64, 64, 0);
        wait_done(200);
        check("norm_in_eng0", 64'(in_hs[0]), 64'(64));
        check("norm_in_eng1", 64'(in_hs[1]), 64'(0));
        check("norm_in_eng2", 64'(in_hs[2]), 64'(0));

        // Backpressure: engine 1, 100 words, sink stalled 80 cycles
        @(posedge clk); #1; sm_tready = 1'b0;
        start_job(1, 100, 100, 100, 1000);
        repeat (69) @(negedge clk);
        check("bp_dready_low", 64'(eng_dready), 64'(0));
        check("bp_writes", 64'(res_idx), 64'(64));
        check("bp_sm_tvalid", 64'(sm_tvalid), 64'(1));
        repeat (10) @(negedge clk);
        @(posedge clk); #1; sm_tready = 1'b1;
        wait_done(300);
        check("bp_results_taken", 64'(res_idx), 64'(100));

        // Routing: engine 2 with toggling ready
        @(posedge clk); #1; route_toggle = 1; chk_route = 1;
        start_job(2, 20, 8, 20, 200);
        wait_done(200);
        check("route_in_eng2", 64'(in_hs[2]), 64'(8));
        check("route_in_eng0", 64'(in_hs[0]), 64'(0));
        check("route_in_eng1", 64'(in_hs[1]), 64'(0));
        @(posedge clk); #1; route_toggle = 0; chk_route = 0; eng_ss_tready = '1;

        // Illegal starts: two-hot, then zero length
        @(posedge clk); #1; ap_start = 3'b011; out_len = 7'd5;
        @(posedge clk); #1; ap_start = '0; out_len = '0;
        @(negedge clk);
        check("ill_twohot_idle", 64'(ap_idle), 64'(1));
        check("ill_twohot_err", 64'(err), 64'(ERR_ON));
        @(posedge clk); #1; ap_start = 3'b010; out_len = 7'd0;
        @(posedge clk); #1; ap_start = '0;
        @(negedge clk);
        check("ill_zerolen_idle", 64'(ap_idle), 64'(1));
        check("ill_zerolen_err", 64'(err), 64'(ERR_ON));
        check("ill_zerolen_sm_tvalid", 64'(sm_tvalid), 64'(0));
        start_job(1, 4, 4, 4, 300);
        wait_done(60);

        // Overrun: 17 results for a 16-word job
        start_job(0, 16, 16, 17, 400);
        wait_done(100);
        check("ovr_err", 64'(err), 64'(ERR_ON));
        check("ovr_taken", 64'(res_idx), 64'(16));

        // Reset mid-job with 10 words buffered
        @(posedge clk); #1; sm_tready = 1'b0;
        start_job(0, 20, 20, 10, 600);
        for (int i = 0; i < 50 && res_idx < 10; i++) @(negedge clk);
        check("mid_fill", 64'(res_idx), 64'(10));
        @(posedge clk); #1; rst_n = 1'b0; exp_q.delete();
        @(negedge clk);
        check("mid_sm_tvalid", 64'(sm_tvalid), 64'(0));
        check("mid_ap_idle", 64'(ap_idle), 64'(1));
        check("mid_sm_tdata", 64'(sm_tdata), 64'(0));
        check("mid_eng_dready", 64'(eng_dready), 64'(0));
        check("mid_ss_tready", 64'(ss_tready), 64'(0));
        @(posedge clk); #1; rst_n = 1'b1; sm_tready = 1'b1;
        start_job(0, 5, 5, 5, 700);
        wait_done(60);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
